// File: rtl/truth_table_recorder.sv
// Truth-table recorder: sweeps every input code of a combinational block,
// waits a fixed settle interval, then writes the sampled outputs into a
// table memory at the address equal to the input code.
module truth_table_recorder #(
    parameter int unsigned IN_W   = 13,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [IN_W-1:0]  dut_x,
    input  logic [OUT_W-1:0] dut_y,
    output logic             wr_valid,
    input  logic             wr_ready,
    output logic [IN_W-1:0]  wr_addr,
    output logic [OUT_W-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [IN_W:0]    count
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSettle = 2'd1;
    localparam logic [1:0] StWrite  = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    localparam logic [3:0]      SettleLoad = 4'(SETTLE - 1);
    localparam logic [3:0]      SettleOne  = 4'd1;
    localparam logic [IN_W-1:0] LastCode   = '1;
    localparam logic [IN_W-1:0] CodeOne    = IN_W'(1);
    localparam logic [IN_W:0]   CountOne   = (IN_W + 1)'(1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       settle_q, settle_d;
    logic [IN_W-1:0]  x_q, x_d;
    logic             valid_q, valid_d;
    logic [IN_W-1:0]  addr_q, addr_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [IN_W:0]    count_q, count_d;
    logic             handshake;

    assign handshake = valid_q && wr_ready;

    // Next-state logic; abort overrides every transition but still counts a
    // write that completes on the same edge.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        x_d      = x_q;
        valid_d  = valid_q;
        addr_d   = addr_q;
        data_d   = data_q;
        busy_d   = busy_q;
        done_d   = done_q;
        count_d  = count_q;

        if (abort) begin
            state_d = StIdle;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            if (state_q == StWrite && handshake) begin
                count_d = count_q + CountOne;
            end
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_d  = StSettle;
                        x_d      = '0;
                        count_d  = '0;
                        busy_d   = 1'b1;
                        done_d   = 1'b0;
                        settle_d = SettleLoad;
                    end
                end
                StSettle: begin
                    if (settle_q == 4'd0) begin
                        data_d  = dut_y;
                        addr_d  = x_q;
                        valid_d = 1'b1;
                        state_d = StWrite;
                    end else begin
                        settle_d = settle_q - SettleOne;
                    end
                end
                StWrite: begin
                    if (handshake) begin
                        valid_d = 1'b0;
                        count_d = count_q + CountOne;
                        if (x_q == LastCode) begin
                            // Final code: dut_x stays at all ones, never wraps.
                            state_d = StDone;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            x_d      = x_q + CodeOne;
                            settle_d = SettleLoad;
                            state_d  = StSettle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State registers with asynchronous reset; a pending write is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            settle_q <= '0;
            x_q      <= '0;
            valid_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            x_q      <= x_d;
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            count_q  <= count_d;
        end
    end

    assign dut_x    = x_q;
    assign wr_valid = valid_q;
    assign wr_addr  = addr_q;
    assign wr_data  = data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;

endmodule

// File: tb/tb_truth_table_recorder.sv
// Bench for truth_table_recorder: small 4-in/4-out table, lookup-table DUT,
// memory model logging accepted writes, and a cycle-level schedule model.
module tb_truth_table_recorder;

    localparam int unsigned IN_W   = 4;
    localparam int unsigned OUT_W  = 4;
    localparam int unsigned SETTLE = 2;
    localparam int NCODES = 1 << IN_W;
    localparam int MAXE   = 400;

    logic clk = 1'b0;
    logic rst, start, abort, wr_ready;
    logic wr_valid, busy, done;
    logic [IN_W-1:0]  dut_x, wr_addr;
    logic [OUT_W-1:0] dut_y, wr_data;
    logic [IN_W:0]    count;

    logic [OUT_W-1:0] lut [NCODES];
    bit               rdy [MAXE];

    int checks = 0;
    int failures = 0;

    // Written only by the monitor below.
    int wa[$];
    int wd[$];
    int hold7 = 0;

    always #5 clk = ~clk;

    // Combinational block under characterisation.
    assign dut_y = lut[dut_x];

    truth_table_recorder #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .SETTLE (SETTLE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .dut_x    (dut_x),
        .dut_y    (dut_y),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .count    (count)
    );

    // Memory model: a write is accepted at the next rising edge when valid and
    // ready are both high while inputs are stable in the low phase.
    always @(negedge clk) begin
        #1;
        if (!rst && wr_valid && wr_ready) begin
            wa.push_back(int'(wr_addr));
            wd.push_back(int'(wr_data));
        end
        if (!rst && wr_valid && wr_addr == 4'd7) hold7 = hold7 + 1;
    end

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; wr_ready = 1'b1;
        for (int k = 0; k < NCODES; k++) lut[k] = OUT_W'(k);
        repeat (2) @(negedge clk);
        checks++;
        if ({dut_x, wr_valid, wr_addr, wr_data, busy, done, count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got x=%0h v=%0b a=%0h d=%0h b=%0b dn=%0b c=%0d want all 0",
                     dut_x, wr_valid, wr_addr, wr_data, busy, done, count);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || wr_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got busy=%0b done=%0b valid=%0b want 0 0 0",
                     busy, done, wr_valid);
        end
    endtask

    // mode 0: identity, ready high; mode 1: 5-cycle stall on code 7;
    // mode 2: random table, random ready, random start pulses while busy.
    task automatic test_sweep(input int mode);
        int e, el, elig7, hs7, exp_done, got, base, h0;
        logic [IN_W:0] prev;
        for (int k = 0; k < NCODES; k++)
            lut[k] = (mode == 2) ? OUT_W'($urandom) : OUT_W'(k);
        for (int i = 0; i < MAXE; i++) begin
            if (mode == 1) rdy[i] = !(i >= 24 && i <= 28);
            else if (mode == 2) rdy[i] = ($urandom_range(0, 3) != 0);
            else rdy[i] = 1'b1;
        end
        rdy[MAXE-1] = 1'b1;

        // Schedule model: edge 0 accepts start; each code settles SETTLE edges,
        // becomes writable one edge later and completes on the first ready edge.
        e = 0; elig7 = 0; hs7 = 0;
        for (int k = 0; k < NCODES; k++) begin
            el = e + SETTLE + 1;
            e = el;
            while (e < MAXE - 1 && !rdy[e]) e++;
            if (k == 7) begin elig7 = el; hs7 = e; end
        end
        exp_done = e;

        @(negedge clk);
        start = 1'b1; abort = 1'b0; wr_ready = rdy[0];
        base = wa.size(); h0 = hold7; got = -1; prev = '0;
        for (int i = 1; i < MAXE; i++) begin
            @(negedge clk);
            if (done) begin got = i - 1; break; end
            checks++;
            if (count < prev) begin
                failures++;
                $display("FAIL sweep%0d_count_monotonic got %0d after %0d", mode, count, prev);
            end
            prev = count;
            start = (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
            wr_ready = rdy[i];
        end
        start = 1'b0;
        wr_ready = 1'b1;

        checks++;
        if (got != exp_done) begin
            failures++;
            $display("FAIL sweep%0d_done_edge got %0d want %0d", mode, got, exp_done);
        end
        checks++;
        if (count !== (IN_W+1)'(NCODES) || busy !== 1'b0 || dut_x !== IN_W'(NCODES - 1)) begin
            failures++;
            $display("FAIL sweep%0d_final got count=%0d busy=%0b x=%0d want %0d 0 %0d",
                     mode, count, busy, dut_x, NCODES, NCODES - 1);
        end
        checks++;
        if (wa.size() - base != NCODES) begin
            failures++;
            $display("FAIL sweep%0d_write_count got %0d want %0d", mode, wa.size() - base, NCODES);
        end
        for (int k = 0; k < NCODES; k++) begin
            if (base + k < wa.size()) begin
                checks++;
                if (wa[base+k] != k || wd[base+k] != int'(lut[k])) begin
                    failures++;
                    $display("FAIL sweep%0d_entry%0d got addr=%0d data=%0d want addr=%0d data=%0d",
                             mode, k, wa[base+k], wd[base+k], k, lut[k]);
                end
            end
        end
        checks++;
        if (hold7 - h0 != hs7 - elig7 + 1) begin
            failures++;
            $display("FAIL sweep%0d_hold7 got %0d cycles want %0d", mode, hold7 - h0,
                     hs7 - elig7 + 1);
        end
    endtask

    task automatic test_abort();
        int base, hit, n, base2;
        for (int k = 0; k < NCODES; k++) lut[k] = OUT_W'(k);
        for (int i = 0; i < MAXE; i++) rdy[i] = (i < 30);
        @(negedge clk);
        start = 1'b1; abort = 1'b0; wr_ready = rdy[0];
        base = wa.size(); hit = 0;
        for (int i = 1; i < 100; i++) begin
            @(negedge clk);
            start = 1'b0;
            wr_ready = rdy[i];
            if (wr_valid && wr_addr == 4'd9) begin abort = 1'b1; hit = 1; break; end
        end
        checks++;
        if (hit != 1) begin
            failures++;
            $display("FAIL abort_reach_addr9 got no write request for addr 9 want one");
        end
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (wr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || count !== 5'd9
            || dut_x !== 4'd9) begin
            failures++;
            $display("FAIL abort_state got v=%0b b=%0b d=%0b c=%0d x=%0d want 0 0 0 9 9",
                     wr_valid, busy, done, count, dut_x);
        end
        repeat (4) @(negedge clk);
        n = wa.size() - base;
        checks++;
        if (n != 9 || (n > 0 && wa[wa.size()-1] != 8) || wr_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_write9 got writes=%0d valid=%0b want 9 writes ending at 8, 0",
                     n, wr_valid);
        end
        // Restart from idle begins again at code 0.
        wr_ready = 1'b1; start = 1'b1;
        base2 = wa.size();
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (count !== '0 || dut_x !== '0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_restart got c=%0d x=%0d busy=%0b want 0 0 1", count, dut_x, busy);
        end
        for (int i = 0; i < 10 && wa.size() == base2; i++) @(negedge clk);
        checks++;
        if (wa.size() == base2 || wa[base2] != 0 || wd[base2] != 0) begin
            failures++;
            $display("FAIL abort_restart_first_write got %0d new writes want addr 0 data 0",
                     wa.size() - base2);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_rst_mid();
        int hit;
        for (int k = 0; k < NCODES; k++) lut[k] = OUT_W'($urandom);
        wr_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        hit = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (dut_x == 4'd10 && !wr_valid && busy) begin hit = 1; break; end
        end
        checks++;
        if (hit != 1) begin
            failures++;
            $display("FAIL rst_reach_code10 got no settle phase at code 10 want one");
        end
        #2;
        rst = 1'b1; start = 1'b1;
        #1;
        checks++;
        if ({dut_x, wr_valid, wr_addr, wr_data, busy, done, count} !== '0) begin
            failures++;
            $display("FAIL rst_async got x=%0h v=%0b a=%0h d=%0h b=%0b dn=%0b c=%0d want all 0",
                     dut_x, wr_valid, wr_addr, wr_data, busy, done, count);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || count !== '0 || dut_x !== '0) begin
            failures++;
            $display("FAIL rst_start_ignored got busy=%0b c=%0d x=%0d want 0 0 0",
                     busy, count, dut_x);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL rst_release_idle got busy=%0b done=%0b want 0 0", busy, done);
        end
    endtask

    task automatic test_start_abort_done();
        test_sweep(0);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL done_hold got done=%0b want 1", done);
        end
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || count !== (IN_W+1)'(NCODES) || dut_x !== 4'hf) begin
            failures++;
            $display("FAIL start_abort_done got done=%0b busy=%0b c=%0d x=%0d want 0 0 16 15",
                     done, busy, count, dut_x);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || wr_valid !== 1'b0) begin
            failures++;
            $display("FAIL start_abort_stays_idle got busy=%0b valid=%0b want 0 0", busy, wr_valid);
        end
    endtask

    initial begin
        test_reset();
        test_sweep(0);
        test_sweep(1);
        test_sweep(2);
        test_abort();
        test_rst_mid();
        test_start_abort_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
